// File: rtl/ft600_pkg.sv
// ft600_pkg: shared widths and default buffer depth for the FT600 emulator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ft600_pkg;

  localparam int FT_DATA_WIDTH = 32;
  localparam int FT_BE_WIDTH   = 4;
  localparam int FT_DEPTH      = 1024;

endpackage

// File: rtl/ft600_emu_fifo.sv
// ft600_emu_fifo: single-clock FIFO with show-ahead head word and occupancy count.
// Latency: a pushed word is visible on o_head one edge after the push when the FIFO was empty.
// Backpressure: push is ignored when full unless a pop happens on the same edge; pop is ignored when empty.
module ft600_emu_fifo
  import ft600_pkg::*;
#(
  parameter int WIDTH = FT_DATA_WIDTH + FT_BE_WIDTH,
  parameter int DEPTH = FT_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full FIFO can still take a word when the head leaves on the same edge.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  // Storage array; not reset, only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks net occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ft600_emu.sv
// ft600_emu: FT600 FIFO-bus emulator bridging FPGA strobes (oe_n/rd_n/wr_n) to a host valid/ready port.
// Latency: host push reaches ft_data/rxf_n after one edge; FPGA write reaches h_rvalid after one edge; zero-wait-state reads.
// Backpressure: txe_n/h_wready are registered fullness; a host word offered to a full read buffer is taken only on an FPGA pop edge.
module ft600_emu
  import ft600_pkg::*;
#(
  parameter int DATA_WIDTH = FT_DATA_WIDTH,
  parameter int DEPTH      = FT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   rxf_n,
  output logic                   txe_n,
  input  logic                   oe_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  inout  wire  [DATA_WIDTH-1:0]  ft_data,
  inout  wire  [FT_BE_WIDTH-1:0] ft_be,
  input  logic [DATA_WIDTH-1:0]  h_wdata,
  input  logic                   h_wvalid,
  output logic                   h_wready,
  output logic [DATA_WIDTH-1:0]  h_rdata,
  output logic [FT_BE_WIDTH-1:0] h_rbe,
  output logic                   h_rvalid,
  input  logic                   h_rready,
  output logic                   err_underrun,
  output logic                   err_overflow,
  output logic                   err_contention
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DATA_WIDTH + FT_BE_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] w_rd_head;
  logic [EW-1:0] w_wr_head;
  logic [CW-1:0] w_rd_count;
  logic [CW-1:0] w_wr_count;
  logic [CW-1:0] w_rd_cnt_nxt;
  logic [CW-1:0] w_wr_cnt_nxt;
  logic          w_rd_empty;
  logic          w_fpga_rd;
  logic          w_rd_pop;
  logic          w_h_push;
  logic          w_wr_push;
  logic          w_h_pop;

  logic          r_rxf_n;
  logic          r_txe_n;
  logic          r_h_wready;
  logic          r_err_underrun;
  logic          r_err_overflow;
  logic          r_err_contention;

  assign w_rd_empty = (w_rd_count == '0);
  assign w_fpga_rd  = !oe_n && !rd_n;
  assign w_rd_pop   = w_fpga_rd && !w_rd_empty;
  // Host word is accepted when there is room, or when the FPGA frees a slot on this same edge.
  assign w_h_push   = h_wvalid && (r_h_wready || w_rd_pop);
  // FPGA write needs the bus turned around (oe_n high) and a slot advertised on txe_n.
  assign w_wr_push  = !wr_n && oe_n && !r_txe_n;
  assign h_rvalid   = (w_wr_count != '0);
  assign w_h_pop    = h_rvalid && h_rready;

  assign w_rd_cnt_nxt = w_rd_count + CW'(w_h_push) - CW'(w_rd_pop);
  assign w_wr_cnt_nxt = w_wr_count + CW'(w_wr_push) - CW'(w_h_pop);

  // Host -> FPGA buffer; host words carry all byte lanes enabled.
  ft600_emu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_rd_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_h_push),
    .i_data  ({{FT_BE_WIDTH{1'b1}}, h_wdata}),
    .i_pop   (w_rd_pop),
    .o_head  (w_rd_head),
    .o_count (w_rd_count)
  );

  // FPGA -> host buffer; byte enables travel with the data word.
  ft600_emu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_wr_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_wr_push),
    .i_data  ({ft_be, ft_data}),
    .i_pop   (w_h_pop),
    .o_head  (w_wr_head),
    .o_count (w_wr_count)
  );

  // The emulator owns the bus whenever the FPGA enables output, even during a write attempt.
  assign ft_data = oe_n ? {DATA_WIDTH{1'bz}}  : w_rd_head[DATA_WIDTH-1:0];
  assign ft_be   = oe_n ? {FT_BE_WIDTH{1'bz}} : w_rd_head[EW-1:DATA_WIDTH];

  assign h_rdata = w_wr_head[DATA_WIDTH-1:0];
  assign h_rbe   = w_wr_head[EW-1:DATA_WIDTH];

  // Status strobes registered from the occupancy each buffer will hold after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxf_n    <= 1'b1;
      r_txe_n    <= 1'b1;
      r_h_wready <= 1'b0;
    end else begin
      r_rxf_n    <= (w_rd_cnt_nxt == '0);
      r_txe_n    <= (w_wr_cnt_nxt == FULL_CNT);
      r_h_wready <= (w_rd_cnt_nxt != FULL_CNT);
    end
  end

  // Sticky protocol-violation flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_underrun   <= 1'b0;
      r_err_overflow   <= 1'b0;
      r_err_contention <= 1'b0;
    end else begin
      if (w_fpga_rd && w_rd_empty) r_err_underrun   <= 1'b1;
      if (!wr_n && r_txe_n)        r_err_overflow   <= 1'b1;
      if (!wr_n && !oe_n)          r_err_contention <= 1'b1;
    end
  end

  assign rxf_n          = r_rxf_n;
  assign txe_n          = r_txe_n;
  assign h_wready       = r_h_wready;
  assign err_underrun   = r_err_underrun;
  assign err_overflow   = r_err_overflow;
  assign err_contention = r_err_contention;

endmodule

// File: tb/tb_ft600_emu.sv
// tb_ft600_emu: directed-vector bench for the FT600 emulator.
// Latency: inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: exercised through full/empty buffer scenarios on both directions.
module tb_ft600_emu;

  logic        clk;
  logic        reset;
  logic        oe_n, rd_n, wr_n;
  logic        tb_drv;
  logic [31:0] tb_data;
  logic [3:0]  tb_be;
  wire  [31:0] ft_data;
  wire  [3:0]  ft_be;
  logic [31:0] h_wdata;
  logic        h_wvalid;
  logic        h_wready;
  logic [31:0] h_rdata;
  logic [3:0]  h_rbe;
  logic        h_rvalid;
  logic        h_rready;
  logic        rxf_n, txe_n;
  logic        err_underrun, err_overflow, err_contention;

  int n_vec;
  int n_err;

  assign ft_data = tb_drv ? tb_data : 32'hzzzz_zzzz;
  assign ft_be   = tb_drv ? tb_be   : 4'hz;

  ft600_emu #(.DATA_WIDTH(32), .DEPTH(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .rxf_n          (rxf_n),
    .txe_n          (txe_n),
    .oe_n           (oe_n),
    .rd_n           (rd_n),
    .wr_n           (wr_n),
    .ft_data        (ft_data),
    .ft_be          (ft_be),
    .h_wdata        (h_wdata),
    .h_wvalid       (h_wvalid),
    .h_wready       (h_wready),
    .h_rdata        (h_rdata),
    .h_rbe          (h_rbe),
    .h_rvalid       (h_rvalid),
    .h_rready       (h_rready),
    .err_underrun   (err_underrun),
    .err_overflow   (err_overflow),
    .err_contention (err_contention)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic host_push(input logic [31:0] d);
    h_wdata  = d;
    h_wvalid = 1'b1;
    tick();
    h_wvalid = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    logic [31:0] exp_w;

    n_vec = 0; n_err = 0;
    reset = 1'b1; oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    tb_drv = 1'b0; tb_data = '0; tb_be = '0;
    h_wdata = '0; h_wvalid = 1'b0; h_rready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_rxf_n",    rxf_n,    1'b1);
    check("rst_txe_n",    txe_n,    1'b1);
    check("rst_h_rvalid", h_rvalid, 1'b0);
    check("rst_h_wready", h_wready, 1'b0);
    check("rst_errs", {err_underrun, err_overflow, err_contention}, 3'b000);
    reset = 1'b0;
    tick();
    check("rel_txe_n",    txe_n,    1'b0);
    check("rel_h_wready", h_wready, 1'b1);
    check("rel_rxf_n",    rxf_n,    1'b1);

    // FPGA write with partial byte enables reaches the host next cycle
    tb_drv = 1'b1; tb_data = 32'hA5A5_A5A5; tb_be = 4'b0011; wr_n = 1'b0;
    #1;
    check("bus_tb_drive", ft_data, 32'hA5A5_A5A5);
    tick();
    wr_n = 1'b1; tb_drv = 1'b0;
    check("wr_h_rvalid", h_rvalid, 1'b1);
    check("wr_h_rdata",  h_rdata,  32'hA5A5_A5A5);
    check("wr_h_rbe",    h_rbe,    4'b0011);
    h_rready = 1'b1;
    tick();
    h_rready = 1'b0;
    check("wr_popped", h_rvalid, 1'b0);

    // Write attempted while the emulator drives the bus
    host_push(32'h0000_0055);
    oe_n = 1'b0; wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
    check("cont_flag",    err_contention, 1'b1);
    check("cont_no_push", h_rvalid,       1'b0);
    check("cont_bus",     ft_data,        32'h0000_0055);
    check("cont_be",      ft_be,          4'hF);
    rd_n = 1'b0;
    tick();
    rd_n = 1'b1; oe_n = 1'b1;
    check("cont_drain_rxf", rxf_n, 1'b1);

    // Zero-wait-state burst read of four host words
    for (int i = 1; i <= 4; i++) host_push(32'(i));
    check("burst_rxf_lo", rxf_n, 1'b0);
    oe_n = 1'b0; rd_n = 1'b0;
    #1;
    bad = 0;
    for (int k = 1; k <= 4; k++) begin
      if (ft_data !== 32'(k)) bad++;
      tick();
    end
    check("burst_order_bad", bad,          0);
    check("burst_rxf_hi",    rxf_n,        1'b1);
    check("burst_underrun",  err_underrun, 1'b0);
    tick();
    oe_n = 1'b1; rd_n = 1'b1;
    check("underrun_flag", err_underrun, 1'b1);

    // Fill the write buffer with the host stalled, then overflow it
    tb_drv = 1'b1; tb_be = 4'hF; wr_n = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      tb_data = 32'h1000_0000 + 32'(i);
      tick();
      if (i == 1022) check("fill_txe_1023", txe_n, 1'b0);
    end
    check("fill_txe_full", txe_n, 1'b1);
    check("fill_no_ovf",   err_overflow, 1'b0);
    tb_data = 32'hDEAD_BEEF;
    tick();
    wr_n = 1'b1; tb_drv = 1'b0;
    check("ovf_flag", err_overflow, 1'b1);
    h_rready = 1'b1;
    n = 0; bad = 0;
    for (int c = 0; c < 1100 && h_rvalid; c++) begin
      if (h_rdata !== 32'h1000_0000 + 32'(n)) bad++;
      n++;
      tick();
    end
    h_rready = 1'b0;
    check("drain_cnt",     n,     1024);
    check("drain_bad",     bad,   0);
    check("drain_txe_lo",  txe_n, 1'b0);

    // Full read buffer: host push and FPGA pop on the same edge
    for (int i = 0; i < 1024; i++) host_push(32'h2000_0000 + 32'(i));
    check("rfull_wready", h_wready, 1'b0);
    h_wdata = 32'hBEEF_0000; h_wvalid = 1'b1;
    oe_n = 1'b0; rd_n = 1'b0;
    #1;
    check("rfull_head", ft_data, 32'h2000_0000);
    tick();
    h_wvalid = 1'b0; rd_n = 1'b1;
    check("rfull_wready_hold", h_wready, 1'b0);
    check("rfull_next_head",   ft_data,  32'h2000_0001);
    rd_n = 1'b0;
    n = 0; bad = 0;
    for (int c = 0; c < 1100 && !rxf_n; c++) begin
      exp_w = (n < 1023) ? 32'h2000_0001 + 32'(n) : 32'hBEEF_0000;
      if (ft_data !== exp_w) bad++;
      n++;
      tick();
    end
    oe_n = 1'b1; rd_n = 1'b1;
    check("rfull_drain_cnt", n,   1024);
    check("rfull_drain_bad", bad, 0);

    // Reset in the middle of a read burst
    for (int i = 0; i < 6; i++) host_push(32'h3000_0000 + 32'(i));
    tb_drv = 1'b1; tb_data = 32'h4444_4444; tb_be = 4'hF; wr_n = 1'b0;
    tick();
    wr_n = 1'b1; tb_drv = 1'b0;
    check("mid_h_rvalid", h_rvalid, 1'b1);
    oe_n = 1'b0; rd_n = 1'b0;
    repeat (3) tick();
    check("mid_head4", ft_data, 32'h3000_0003);
    oe_n = 1'b1; rd_n = 1'b1;
    reset = 1'b1;
    tick();
    check("mid_rst_rxf",   rxf_n,    1'b1);
    check("mid_rst_rval",  h_rvalid, 1'b0);
    check("mid_rst_txe",   txe_n,    1'b1);
    check("mid_rst_wrdy",  h_wready, 1'b0);
    check("mid_rst_errs", {err_underrun, err_overflow, err_contention}, 3'b000);
    reset = 1'b0;
    tick();
    check("mid_rel_txe",  txe_n,    1'b0);
    check("mid_rel_wrdy", h_wready, 1'b1);
    check("mid_rel_rxf",  rxf_n,    1'b1);
    host_push(32'h5555_0001);
    oe_n = 1'b0;
    #1;
    check("mid_new_head", ft_data, 32'h5555_0001);
    oe_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ft600_emu.md
FT600_EMU -- requirements
Module: ft600_emu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: FT600 data bus width in bits.
REQ-002 Parameter DEPTH, default 1024: words per direction buffer (4 kB at 32 bit); power of two.
REQ-003 clk  input  1  FT600 interface clock; everything is on the rising edge; one clock, no other domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rxf_n  output  1  low = read buffer holds at least one word for the FPGA.
REQ-006 txe_n  output  1  low = write buffer can accept a word from the FPGA.
REQ-007 oe_n, rd_n, wr_n  input  1 each  FPGA-side strobes, active low.
REQ-008 ft_data  inout  DATA_WIDTH  shared bus; ft_be  inout  4  byte enables.
REQ-009 h_wdata  input  DATA_WIDTH; h_wvalid  input  1; h_wready  output  1  host push into the read buffer.
REQ-010 h_rdata  output  DATA_WIDTH; h_rbe  output  4; h_rvalid  output  1; h_rready  input  1  host pop from the write buffer.
REQ-011 err_underrun, err_overflow, err_contention  output  1 each  sticky error flags.

Function
REQ-012 ft_data SHALL be driven with the read-buffer head word, and ft_be with 4'b1111, while oe_n=0; otherwise both SHALL be high-Z.
REQ-013 Read pop: at an edge with oe_n=0, rd_n=0 and the read buffer non-empty, the head word SHALL be consumed; the next word SHALL appear on ft_data after that edge (zero wait states).
REQ-014 Write push: at an edge with wr_n=0, oe_n=1 and txe_n=0, {ft_be, ft_data} SHALL be stored in the write buffer.
REQ-015 rxf_n and txe_n SHALL be registers that reflect the buffer occupancy after each edge: rxf_n=1 iff the read buffer is empty, txe_n=1 iff the write buffer holds DEPTH words.
REQ-016 h_wready SHALL be 1 iff the read buffer is not full; a push occurs at an edge with h_wvalid and h_wready both 1.
REQ-017 h_rvalid SHALL be 1 iff the write buffer is non-empty, with h_rdata/h_rbe showing its head; a pop occurs at an edge with h_rvalid and h_rready both 1.
REQ-018 A simultaneous push and pop on the same buffer SHALL leave its count unchanged and SHALL be legal when the buffer is full or empty, provided each side's own condition holds.
REQ-019 Occupancy counters SHALL be log2(DEPTH)+1 bits; pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 rd_n=0 with oe_n=0 while the read buffer is empty SHALL set err_underrun; no pop occurs.
REQ-021 wr_n=0 while txe_n=1 SHALL set err_overflow; the word is dropped.
REQ-022 wr_n=0 together with oe_n=0 SHALL set err_contention; the write is ignored and the bus stays driven by the emulator.
REQ-023 Error flags SHALL clear only on reset.

Reset
REQ-024 While reset=1: both buffers SHALL be emptied and pointers zeroed; rxf_n=1, txe_n=1, h_rvalid=0, h_wready=0, all error flags 0.
REQ-025 The first edge with reset=0 SHALL load txe_n=0 and set h_wready=1; rxf_n SHALL stay 1 until the first push.
REQ-026 Reset asserted mid-burst SHALL discard all buffered words with no residual pop or push.

Structure
REQ-027 Package ft600_pkg SHALL hold FT_DATA_WIDTH, FT_BE_WIDTH=4 and the default DEPTH constants.
REQ-028 Both buffers SHALL be instances of one sub-module, ft600_emu_fifo (synchronous FIFO, show-ahead head, count output, width DATA_WIDTH+4).

Verification
REQ-029 Push 0x00000001..0x00000004 from the host, then hold oe_n=0 and rd_n=0 for 4 cycles -> the FPGA samples 1,2,3,4 on consecutive edges and rxf_n=1 after the 4th edge, err_underrun=0.
REQ-030 FPGA writes 0xA5A5A5A5 with ft_be=4'b0011 -> h_rvalid=1 on the next cycle, h_rdata=0xA5A5A5A5, h_rbe=4'b0011.
REQ-031 FPGA writes 1024 words with the host stalled -> txe_n=1 after the 1024th edge; a 1025th write sets err_overflow and h_rvalid count stays 1024.
REQ-032 Full read buffer with a host push and an FPGA pop on the same edge -> count stays 1024, h_wready stays 0, word order is preserved.
REQ-033 wr_n=0 and oe_n=0 in the same cycle -> err_contention=1 and no write-buffer push.
REQ-034 Reset pulsed after 3 of 6 words have been read -> rxf_n=1, h_rvalid=0, flags 0; after release txe_n=0 and h_wready=1.
